// File: rtl/i2c_frame_assembler.sv
// Header-led byte stream to parallel frame assembler with valid/ready output.
// Optional trailing XOR checksum byte when FRAME_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module i2c_frame_assembler #(
  parameter int OPERAND_W      = 32,
  parameter int NUM_OPERANDS   = 3,
  parameter int OPCODE_W       = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic byte_flag,
  input  logic [7:0] byte_data,
  input  logic frame_ready,
  output logic frame_valid,
  output logic [OPCODE_W-1:0] frame_opcode,
  output logic [NUM_OPERANDS*OPERAND_W-1:0] frame_payload,
  output logic busy,
  output logic [$clog2(NUM_OPERANDS*OPERAND_W/8+1)-1:0] byte_index,
  output logic err_timeout,
  output logic err_overrun,
  output logic err_checksum
);
  localparam int NB = NUM_OPERANDS * OPERAND_W / 8;
  localparam int PW = NB * 8;
  localparam int IW = $clog2(NB + 1);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] NB_I = IW'(NB);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LOAD =
    TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT
`ifdef FRAME_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t state_q;
  logic s1_q, s2_q, s3_q, vld_q, arm_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] cnt_q;
  logic [PW-1:0] asm_q;
  logic [OPCODE_W-1:0] op_q;
  logic valid_q;
  logic [OPCODE_W-1:0] fop_q;
  logic [PW-1:0] fpl_q;
  logic to_q, ov_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] cks_q;
  logic ck_q;
`endif

  logic strobe, is_hdr, expired, take;
  logic [IW-1:0] idx_inc;

  // arm_q blocks a flag that was already high when reset released
  assign strobe  = s2_q & ~s3_q & arm_q;
  assign is_hdr  = &byte_data[7:OPCODE_W];
  assign idx_inc = (idx_q == NB_I) ? idx_q : idx_q + IW'(1);
  assign expired = TO_EN && (cnt_q == '0) && !strobe;
  assign take    = !valid_q || frame_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 1'b0;
      arm_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      fop_q   <= '0;
      fpl_q   <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      cks_q   <= '0;
      ck_q    <= 1'b0;
`endif
    end else begin
      s1_q  <= byte_flag;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      vld_q <= 1'b1;
      arm_q <= arm_q | (vld_q & ~s1_q);
      to_q  <= 1'b0;
      ov_q  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      ck_q  <= 1'b0;
`endif
      if (valid_q && frame_ready)
        valid_q <= 1'b0;
      if (strobe)
        cnt_q <= TO_LOAD;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - TW'(1);

      unique case (state_q)
        S_IDLE: begin
          if (strobe && is_hdr) begin
            op_q    <= byte_data[OPCODE_W-1:0];
            idx_q   <= '0;
            state_q <= S_COLLECT;
`ifdef FRAME_CHECKSUM_EN
            cks_q   <= byte_data;
`endif
          end
        end
        S_COLLECT: begin
          if (strobe) begin
            asm_q <= PW'({asm_q, byte_data});
            idx_q <= idx_inc;
`ifdef FRAME_CHECKSUM_EN
            cks_q <= cks_q ^ byte_data;
            if (idx_inc == NB_I)
              state_q <= S_CHECK;
`else
            if (idx_inc == NB_I)
              state_q <= S_COMMIT;
`endif
          end else if (expired) begin
            to_q    <= 1'b1;
            idx_q   <= '0;
            state_q <= S_IDLE;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (strobe) begin
            if (byte_data == cks_q) begin
              state_q <= S_COMMIT;
            end else begin
              ck_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (expired) begin
            to_q    <= 1'b1;
            idx_q   <= '0;
            state_q <= S_IDLE;
          end
        end
`endif
        S_COMMIT: begin
          if (take) begin
            fop_q   <= op_q;
            fpl_q   <= asm_q;
            valid_q <= 1'b1;
          end else begin
            ov_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_valid   = valid_q;
  assign frame_opcode  = fop_q;
  assign frame_payload = fpl_q;
  assign busy          = (state_q != S_IDLE);
  assign byte_index    = idx_q;
  assign err_timeout   = to_q;
  assign err_overrun   = ov_q;
`ifdef FRAME_CHECKSUM_EN
  assign err_checksum  = ck_q;
`else
  assign err_checksum  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_frame_assembler.sv
// Directed bench for i2c_frame_assembler with a frame scoreboard.
// Checksum steps are built in when FRAME_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_i2c_frame_assembler;
  localparam int NB = 12;
  localparam int PW = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic byte_flag = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic frame_ready = 1'b1;
  logic frame_valid;
  logic [1:0] frame_opcode;
  logic [PW-1:0] frame_payload;
  logic busy;
  logic [3:0] byte_index;
  logic err_timeout, err_overrun, err_checksum;

  i2c_frame_assembler dut (
    .clk(clk),
    .rst(rst),
    .byte_flag(byte_flag),
    .byte_data(byte_data),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .frame_opcode(frame_opcode),
    .frame_payload(frame_payload),
    .busy(busy),
    .byte_index(byte_index),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_checksum(err_checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    op;
    logic [PW-1:0] pl;
  } frm_t;

  frm_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_to = 0, n_ov = 0, n_ck = 0;
  int n_vhi = 0, n_acc = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    frm_t e;
    if (rst) begin
      if (err_timeout) n_to++;
      if (err_overrun) n_ov++;
      if (err_checksum) n_ck++;
      if (frame_valid) n_vhi++;
      if (frame_valid && frame_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_opcode", 128'(frame_opcode), 128'(e.op));
          chk("sb_payload", 128'(frame_payload), 128'(e.pl));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    repeat (3) @(negedge clk);
    byte_data = b;
    byte_flag = 1'b1;
    repeat (hold) @(negedge clk);
    byte_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr,
                            input logic [PW-1:0] pl,
                            input int hold,
                            input logic [7:0] flip);
    logic [7:0] x;
    logic [7:0] b;
    x = hdr;
    send_byte(hdr, hold);
    for (int i = 0; i < NB; i++) begin
      b = pl[PW-1-8*i -: 8];
      x = x ^ b;
      send_byte(b, hold);
    end
`ifdef FRAME_CHECKSUM_EN
    send_byte(x ^ flip, hold);
`endif
    $display("frame hdr %0h xor %0h flip %0h", hdr, x, flip);
  endtask

  initial begin
    int n, v0, a0, t0, o0, c0;
    logic [PW-1:0] pa, pb;

    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(frame_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_index", 128'(byte_index), 128'd0);
    chk("rst_payload", 128'(frame_payload), 128'd0);
    chk("rst_opcode", 128'(frame_opcode), 128'd0);
    chk("rst_to", 128'(err_timeout), 128'd0);
    chk("rst_ov", 128'(err_overrun), 128'd0);
    chk("rst_ck", 128'(err_checksum), 128'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic frame
    pa = 96'h40000000_40000000_40800000;
    exp_q.push_back('{op: 2'b10, pl: pa});
    v0 = n_vhi;
    a0 = n_acc;
    send_frame(8'hFE, pa, 4, 8'h00);
    repeat (6) @(negedge clk);
    chk("t1_valid_cycles", 128'(n_vhi - v0), 128'd1);
    chk("t1_accepted", 128'(n_acc - a0), 128'd1);
    chk("t1_busy", 128'(busy), 128'd0);
    chk("t1_index_sat", 128'(byte_index), 128'd12);

    // 2: non-header bytes in IDLE
    send_byte(8'h12, 4);
    repeat (4) @(negedge clk);
    chk("t2_busy_a", 128'(busy), 128'd0);
    send_byte(8'h7C, 4);
    repeat (4) @(negedge clk);
    chk("t2_busy_b", 128'(busy), 128'd0);
    chk("t2_valid", 128'(frame_valid), 128'd0);
    chk("t2_index", 128'(byte_index), 128'd12);

    // 3: timeout after 5 payload bytes
    send_byte(8'hFD, 4);
    repeat (2) @(negedge clk);
    chk("t3_busy", 128'(busy), 128'd1);
    chk("t3_index0", 128'(byte_index), 128'd0);
    for (int i = 0; i < 4; i++)
      send_byte(8'(8'h11 * (i + 1)), 4);
    repeat (3) @(negedge clk);
    byte_data = 8'h55;
    byte_flag = 1'b1;
    n = 0;
    while (byte_index !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_fifth", 128'(byte_index), 128'd5);
    t0 = n_to;
    n = 0;
    while (err_timeout !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
      if (n == 3) byte_flag = 1'b0;
    end
    chk("t3_timeout_clks", 128'(n), 128'd1000);
    @(negedge clk);
    chk("t3_to_count", 128'(n_to - t0), 128'd1);
    chk("t3_busy_after", 128'(busy), 128'd0);
    chk("t3_index_after", 128'(byte_index), 128'd0);
    pa = 96'h12345678_9ABCDEF0_0F1E2D3C;
    exp_q.push_back('{op: 2'b10, pl: pa});
    send_frame(8'hFE, pa, 4, 8'h00);
    repeat (6) @(negedge clk);
    chk("t3_sb_drained", 128'(exp_q.size()), 128'd0);

    // 4: overrun with ready low
    @(posedge clk);
    #1 frame_ready = 1'b0;
    pa = 96'h00000001_00000002_00000003;
    pb = 96'h0A0B0C0D_11223344_55667788;
    exp_q.push_back('{op: 2'b11, pl: pa});
    send_frame(8'hFF, pa, 4, 8'h00);
    repeat (4) @(negedge clk);
    chk("t4_valid_a", 128'(frame_valid), 128'd1);
    o0 = n_ov;
    send_frame(8'hFC, pb, 4, 8'h00);
    repeat (4) @(negedge clk);
    chk("t4_overrun", 128'(n_ov - o0), 128'd1);
    chk("t4_held_pl", 128'(frame_payload), 128'(pa));
    chk("t4_held_op", 128'(frame_opcode), 128'd3);
    chk("t4_held_valid", 128'(frame_valid), 128'd1);
    @(posedge clk);
    #1 frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_fall", 128'(frame_valid), 128'd0);

    // 5: long flag holds and reset mid-frame
    send_byte(8'hFE, 50);
    for (int i = 0; i < 5; i++)
      send_byte(8'(8'h21 + i), 50);
    chk("t5_index5", 128'(byte_index), 128'd5);
    repeat (3) @(negedge clk);
    byte_data = 8'h99;
    byte_flag = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_index6", 128'(byte_index), 128'd6);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_busy_rst", 128'(busy), 128'd0);
    chk("t5_index_rst", 128'(byte_index), 128'd0);
    chk("t5_valid_rst", 128'(frame_valid), 128'd0);
    byte_flag = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_busy_idle", 128'(busy), 128'd0);
    pa = 96'hCAFEF00D_DEADBEEF_01020304;
    exp_q.push_back('{op: 2'b01, pl: pa});
    a0 = n_acc;
    send_frame(8'hFD, pa, 50, 8'h00);
    repeat (6) @(negedge clk);
    chk("t5_accepted", 128'(n_acc - a0), 128'd1);

    // 6: checksum
    c0 = n_ck;
    o0 = n_ov;
`ifdef FRAME_CHECKSUM_EN
    pa = 96'h40000000_40000000_40800000;
    exp_q.push_back('{op: 2'b10, pl: pa});
    a0 = n_acc;
    send_frame(8'hFE, pa, 4, 8'h00);
    repeat (6) @(negedge clk);
    chk("t6_good_acc", 128'(n_acc - a0), 128'd1);
    a0 = n_acc;
    send_frame(8'hFE, pa, 4, 8'h01);
    repeat (6) @(negedge clk);
    chk("t6_bad_acc", 128'(n_acc - a0), 128'd0);
    chk("t6_ck_pulse", 128'(n_ck - c0), 128'd1);
    chk("t6_no_ov", 128'(n_ov - o0), 128'd0);
`else
    chk("t6_ck_tied", 128'(n_ck - c0), 128'd0);
    chk("t6_ck_pin", 128'(err_checksum), 128'd0);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
